// File: rtl/tl_ul_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tl_ul_arb_ctrl
//
// Four-master TL-UL A-channel arbiter with in-order D-channel response routing.
// The A payload mux and D payload fan-out live outside this block; this block
// only produces the select indices and the valid/ready handshakes.
//
// Arbitration is round-robin. Once a grant is offered to the slave and stalled,
// it is locked until the beat is accepted, so a stalled A beat never changes
// source. Every accepted A beat pushes its master index into a tracking FIFO;
// D beats are routed to the master at the FIFO head, in acceptance order.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   m_a_valid / m_a_ready per-master A handshake (bit i = master i)
//   a_sel                 granted master index (A payload mux select)
//   s_a_valid / s_a_ready A handshake towards the slave
//   s_d_valid / s_d_ready D handshake from the slave
//   m_d_valid / m_d_ready per-master D handshake
//   d_sel                 master index at FIFO head (D routing select)
//   outstanding           accepted A beats not yet answered on D
//   full                  outstanding == DEPTH, A side is blocked
//   err_unexp_d           one-cycle pulse: D valid seen with nothing outstanding
// -----------------------------------------------------------------------------
module tl_ul_arb_ctrl #(
   parameter int DEPTH = 4   // max outstanding A beats, power of two in 2..16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               m_a_valid,
   output logic [3:0]               m_a_ready,
   output logic [1:0]               a_sel,
   output logic                     s_a_valid,
   input  logic                     s_a_ready,
   input  logic                     s_d_valid,
   output logic                     s_d_ready,
   output logic [3:0]               m_d_valid,
   input  logic [3:0]               m_d_ready,
   output logic [1:0]               d_sel,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     full,
   output logic                     err_unexp_d
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {
      ST_ARB,
      ST_LOCK
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [1:0]      lock_id_q, lock_id_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q;
   logic [1:0]      fifo_q [DEPTH];

   logic [1:0]      rr_sel;
   logic            a_fire;
   logic            d_fire;
   logic            nonempty;

   // --------------------------------------------------------------------------
   // Round-robin pick: first requesting master at or after rr_ptr, mod 4.
   // Scanning from the far end down lets the nearest requester win last.
   // With no requester the pick rests on rr_ptr.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no
      // path leaves it unassigned; otherwise synthesis infers a latch.
      rr_sel = rr_ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (m_a_valid[rr_ptr_q + 2'(k)]) begin
            rr_sel = rr_ptr_q + 2'(k);
         end
      end
   end

   assign a_sel     = (state_q == ST_LOCK) ? lock_id_q : rr_sel;
   assign full      = (cnt_q == DEPTH_C);
   // No full bypass: a D pop in the same cycle does not open the A side.
   assign s_a_valid = m_a_valid[a_sel] & ~full;
   assign a_fire    = s_a_valid & s_a_ready;
   assign m_a_ready = a_fire ? (4'b0001 << a_sel) : 4'b0000;

   // --------------------------------------------------------------------------
   // Grant FSM: ARB picks combinationally; a stalled offer locks the grant.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      unique case (state_q)
         ST_ARB: begin
            if (s_a_valid && !s_a_ready) begin
               state_d   = ST_LOCK;
               lock_id_d = a_sel;
            end
         end
         ST_LOCK: begin
            // Release on acceptance. A master that illegally withdraws its
            // valid also releases the lock rather than starving the others.
            if (a_fire || !s_a_valid) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   assign rr_ptr_d = a_fire ? (a_sel + 2'd1) : rr_ptr_q;

   // --------------------------------------------------------------------------
   // D routing from the tracking FIFO head. An empty FIFO routes nowhere.
   // --------------------------------------------------------------------------
   assign nonempty  = (cnt_q != '0);
   assign d_sel     = nonempty ? fifo_q[rd_ptr_q] : 2'd0;
   assign m_d_valid = (nonempty && s_d_valid) ? (4'b0001 << d_sel) : 4'b0000;
   assign s_d_ready = nonempty & m_d_ready[d_sel];
   assign d_fire    = s_d_valid & s_d_ready;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({a_fire, d_fire})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   assign outstanding = cnt_q;
   assign err_unexp_d = err_q;

   // --------------------------------------------------------------------------
   // Control state
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ARB;
         rr_ptr_q  <= 2'd0;
         lock_id_q <= 2'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         lock_id_q <= lock_id_d;
         cnt_q     <= cnt_d;
         err_q     <= s_d_valid & ~nonempty;
         if (a_fire) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (d_fire) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // NOTE: the FIFO storage has no reset; an entry is only read while the
   // occupancy count covers it, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (a_fire) begin
         fifo_q[wr_ptr_q] <= a_sel;
      end
   end

endmodule

// File: doc/tl_ul_arb_ctrl.md
TL_UL_ARB_CTRL -- requirements
Module: tl_ul_arb_ctrl

Interface
- REQ-001: Parameter DEPTH, default 4, is the max outstanding A transactions; legal values are powers of two, 2..16.
- REQ-002: clk  input  1  clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: m_a_valid  input  4  per-master A-channel request valid, bit i = master i.
- REQ-005: m_a_ready  output  4  per-master A-channel ready.
- REQ-006: a_sel  output  2  granted master index; drives the external A payload mux.
- REQ-007: s_a_valid  output  1  A valid to slave.
- REQ-008: s_a_ready  input  1  A ready from slave.
- REQ-009: s_d_valid  input  1  D valid from slave.
- REQ-010: s_d_ready  output  1  D ready to slave.
- REQ-011: m_d_valid  output  4  per-master D valid.
- REQ-012: m_d_ready  input  4  per-master D ready.
- REQ-013: d_sel  output  2  master index at tracking-FIFO head; drives the external D routing.
- REQ-014: outstanding  output  log2(DEPTH)+1  count of A fires not yet answered on D.
- REQ-015: full  output  1  outstanding == DEPTH.
- REQ-016: err_unexp_d  output  1  registered one-cycle pulse flagging D valid with no outstanding request.

Function
- REQ-017: Define a_fire = s_a_valid & s_a_ready and d_fire = s_d_valid & s_d_ready.
- REQ-018: FSM has two states. ARB: a_sel is combinational round-robin, starting at rr_ptr and ascending mod 4 to the first asserted m_a_valid. LOCK: a_sel equals the registered lock_id.
- REQ-019: ARB->LOCK when s_a_valid=1 and s_a_ready=0; lock_id captures a_sel.
- REQ-020: LOCK->ARB on a_fire.
- REQ-021: In LOCK, grant never changes while the master holds valid; a_sel stays stable while s_a_valid=1 and s_a_ready=0.
- REQ-022: s_a_valid = m_a_valid[a_sel] & ~full.
- REQ-023: m_a_ready[i] = s_a_ready & ~full & (a_sel==i) & m_a_valid[i]; all other bits are 0.
- REQ-024: With no m_a_valid asserted in ARB, a_sel = rr_ptr and s_a_valid = 0.
- REQ-025: On a_fire, rr_ptr <= (a_sel+1) mod 4; otherwise rr_ptr holds.
- REQ-026: Tracking FIFO depth is DEPTH, entry width 2. On a_fire, push a_sel; on d_fire, pop the head. Pointers wrap mod DEPTH.
- REQ-027: outstanding changes by +1 on a_fire only, -1 on d_fire only, and is unchanged on both in the same cycle.
- REQ-028: When full=1, s_a_valid=0 and m_a_ready=0, even if d_fire occurs in the same cycle (no full bypass).
- REQ-029: When outstanding>0: d_sel = head entry; m_d_valid[d_sel] = s_d_valid; other m_d_valid bits are 0; s_d_ready = m_d_ready[d_sel].
- REQ-030: When outstanding==0: m_d_valid=0, s_d_ready=0, d_sel=0; err_unexp_d is asserted the cycle after any cycle with s_d_valid=1.
- REQ-031: Responses are in order. The slave returns D in A-acceptance order; no source-ID reordering.
- REQ-032: A-to-grant latency is 0 cycles (combinational). FIFO push is visible on d_sel the cycle after a_fire; there is no same-cycle A->D bypass.

Reset
- REQ-033: While rst_n=0, the following hold: state=ARB, rr_ptr=0, lock_id=0, FIFO pointers=0, outstanding=0, full=0, err_unexp_d=0.
- REQ-034: While rst_n=0, combinational outputs resolve to: s_a_valid follows REQ-022, s_d_ready=0, m_d_valid=0.
- REQ-035: Reset asserted mid-transaction discards all outstanding entries; D beats arriving after reset release with an empty FIFO raise err_unexp_d.

Verification
- REQ-036: All four m_a_valid held at 1 with s_a_ready=1 and D answered each cycle -> grants in order 0,1,2,3,0; each master's m_a_ready is high once per 4 cycles.
- REQ-037: rr_ptr=0, m_a_valid=0001, s_a_ready=0 for 3 cycles; m_a_valid=1001 raised during the stall -> a_sel stays 0 throughout the stall and fires on master 0 first; next grant is 3.
- REQ-038: DEPTH=4, s_d_valid=0, continuous requests -> 4 fires, then full=1, outstanding=4, s_a_valid=0. A single d_fire with a pending request -> 5th fire on the following cycle.
- REQ-039: Fires from masters 2,0,3 -> D beats route to m_d_valid bits 2,0,3 in order. m_d_ready[0]=0 for 2 cycles -> s_d_ready=0 and the head holds.
- REQ-040: s_d_valid=1 with outstanding=0 -> err_unexp_d=1 for one cycle, s_d_ready=0.
- REQ-041: rst_n pulsed low with outstanding=3 -> outstanding=0, rr_ptr=0 on release.
